uart_tx: RTL



---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_baud_tick.sv | 40 ++++
 rtl/uart_tx.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types and constants for the UART transmitter and the
//                baud tick generator. The state encoding keeps PARITY present
//                in every build so state values never shift between builds.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int DATA_BITS  = 8;
    localparam int TOGGLE_BIT = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_tx_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_baud_tick.sv
// ============================================================================
//  Module      : uart_baud_tick
//  Description : Bit-period counter. Counts 0..CLKS_PER_BIT-1 and wraps,
//                raising tick_o for the single cycle in which the count sits
//                at CLKS_PER_BIT-1. clear_i holds the count at zero so the
//                next bit period starts aligned to the cycle clear drops.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 434,
    parameter int CNT_WIDTH    = $clog2(CLKS_PER_BIT)
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    output logic tick_o
);

    localparam logic [CNT_WIDTH-1:0] C_LAST = CNT_WIDTH'(CLKS_PER_BIT - 1);

    logic [CNT_WIDTH-1:0] cnt_q;

    // Free-running bit-period counter, held at zero while cleared
    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            cnt_q <= '0;
        end else if (cnt_q == C_LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_WIDTH'(1);
        end
    end

    assign tick_o = (cnt_q == C_LAST) && !clear_i;

endmodule

`default_nettype wire

// File: rtl/uart_tx.sv
// ============================================================================
//  Module      : uart_tx
//  Description : 8N1 serial transmitter driven by a toggle-request word.
//                A flip of uart_tx_data[8] while idle latches the byte in
//                uart_tx_data[7:0] and sends start, 8 data bits LSB first and
//                a stop bit. tx and uart_tx_sending are registered, so they
//                follow a request by one cycle.
//                Build option UART_TX_PARITY_EN inserts an even-parity bit
//                between the data bits and the stop bit (11-bit frame).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int CNT_WIDTH    = $clog2(CLKS_PER_BIT)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [8:0] uart_tx_data,
    output logic       uart_tx_sending,
    output logic       tx
);

    localparam int                 C_IDX_W    = $clog2(DATA_BITS);
    localparam logic [C_IDX_W-1:0] C_LAST_IDX = C_IDX_W'(DATA_BITS - 1);

    uart_tx_state_t       state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [C_IDX_W-1:0]   bit_idx_q, bit_idx_d;
    logic                 last_toggle_q, last_toggle_d;
    logic                 tx_q, tx_d;
    logic                 sending_q, sending_d;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    logic w_req;
    logic w_tick;
    logic w_baud_clr;

    // Requests are only honoured in IDLE; a toggle seen mid-frame stays
    // pending because last_toggle is not updated until it is serviced.
    assign w_req      = (state_q == IDLE) && (uart_tx_data[TOGGLE_BIT] != last_toggle_q);
    // Holding the counter clear in IDLE makes START begin at count zero.
    assign w_baud_clr = (state_q == IDLE);

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CNT_WIDTH    (CNT_WIDTH)
    ) u_baud (
        .clk     (clk),
        .rst     (rst),
        .clear_i (w_baud_clr),
        .tick_o  (w_tick)
    );

    // State register and registered line outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            shift_q       <= '0;
            bit_idx_q     <= '0;
            last_toggle_q <= uart_tx_data[TOGGLE_BIT];
            tx_q          <= 1'b1;
            sending_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q      <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            shift_q       <= shift_d;
            bit_idx_q     <= bit_idx_d;
            last_toggle_q <= last_toggle_d;
            tx_q          <= tx_d;
            sending_q     <= sending_d;
`ifdef UART_TX_PARITY_EN
            parity_q      <= parity_d;
`endif
        end
    end

    // Next-state logic; outputs are decoded from the next state so the
    // registered line matches the state it belongs to.
    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        bit_idx_d     = bit_idx_q;
        last_toggle_d = last_toggle_q;
`ifdef UART_TX_PARITY_EN
        parity_d      = parity_q;
`endif

        case (state_q)
            IDLE: begin
                if (w_req) begin
                    shift_d       = uart_tx_data[DATA_BITS-1:0];
                    last_toggle_d = uart_tx_data[TOGGLE_BIT];
                    bit_idx_d     = '0;
                    state_d       = START;
`ifdef UART_TX_PARITY_EN
                    parity_d      = ^uart_tx_data[DATA_BITS-1:0];
`endif
                end
            end
            START: begin
                if (w_tick) begin
                    bit_idx_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (w_tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == C_LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + C_IDX_W'(1);
                    end
                end
            end
            PARITY: begin
`ifdef UART_TX_PARITY_EN
                if (w_tick) begin
                    state_d = STOP;
                end
`else
                state_d = IDLE;
`endif
            end
            STOP: begin
                if (w_tick) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        sending_d = (state_d != IDLE);
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = parity_d;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    assign tx              = tx_q;
    assign uart_tx_sending = sending_q;

endmodule

`default_nettype wire
